// File: rtl/urna_multicandidato.sv
// Ballot-box controller: collects BCD key digits, counts confirmed votes per candidate/null/blank.
// Build option: define URNA_SAT_EN for saturating counters (default build wraps modulo 2^CNT_W).
module urna_multicandidato #(
  parameter int NUM_CAND    = 4,
  parameter int CODE_DIGITS = 4,
  parameter int CNT_W       = 8,
  parameter logic [NUM_CAND*CODE_DIGITS*4-1:0] CODES = {16'h3509, 16'h3502, 16'h3492, 16'h3474}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       digit,
  input  logic             valid,
  input  logic             confirm,
  input  logic             cancel,
  input  logic             finish,
  input  logic             clear,
  input  logic [3:0]       sel,
  output logic [CNT_W-1:0] tally,
  output logic             tally_valid,
  output logic             vote_done,
  output logic             votestatus
);

  localparam int CODE_W = CODE_DIGITS * 4;
  localparam int NSLOT  = NUM_CAND + 2;
  localparam int NW     = $clog2(CODE_DIGITS + 1);
  localparam logic [NW-1:0] LAST_DIG  = NW'(CODE_DIGITS - 1);
  localparam logic [3:0]    SEL_NULL  = 4'(NUM_CAND);
  localparam logic [3:0]    SEL_BLANK = 4'(NUM_CAND + 1);

  typedef enum logic [1:0] {ENTER = 2'd0, WAIT_CONF = 2'd1, CLOSED = 2'd2} state_t;

  state_t            state_r;
  logic [NW-1:0]     ndig_r;
  logic              bad_r;
  logic [CODE_W-1:0] code_r;
  logic [CNT_W-1:0]  cnt_r [NSLOT];

  logic              hit_s;
  logic [3:0]        hit_idx_s;
  logic              cnt_en_s;
  logic [3:0]        cnt_idx_s;
  logic [CNT_W-1:0]  rd_s;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef URNA_SAT_EN
    bump = (&v) ? v : v + CNT_W'(1);
`else
    bump = v + CNT_W'(1);
`endif
  endfunction

  // Match the entered code against the candidate table; lowest index wins.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = SEL_NULL;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (code_r == CODES[i*CODE_W +: CODE_W]) begin
        hit_s     = 1'b1;
        hit_idx_s = 4'(i);
      end else begin
        hit_s     = hit_s;
        hit_idx_s = hit_idx_s;
      end
    end
  end

  // Decide whether this edge counts a vote and which counter it lands in.
  always_comb begin
    cnt_en_s  = 1'b0;
    cnt_idx_s = SEL_NULL;
    if (!finish && !cancel && confirm) begin
      if (state_r == WAIT_CONF) begin
        cnt_en_s  = 1'b1;
        cnt_idx_s = (hit_s && !bad_r) ? hit_idx_s : SEL_NULL;
      end else if (state_r == ENTER && ndig_r == NW'(0) && !valid) begin
        cnt_en_s  = 1'b1;
        cnt_idx_s = SEL_BLANK;
      end else begin
        cnt_en_s  = 1'b0;
        cnt_idx_s = SEL_NULL;
      end
    end else begin
      cnt_en_s  = 1'b0;
      cnt_idx_s = SEL_NULL;
    end
  end

  // Readout mux; out-of-range selects read zero.
  always_comb begin
    rd_s = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (sel == 4'(i)) begin
        rd_s = cnt_r[i];
      end else begin
        rd_s = rd_s;
      end
    end
  end

  // Voting FSM, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ENTER;
      ndig_r      <= '0;
      bad_r       <= 1'b0;
      code_r      <= '0;
      tally       <= '0;
      tally_valid <= 1'b0;
      vote_done   <= 1'b0;
      votestatus  <= 1'b0;
      for (int i = 0; i < NSLOT; i++) cnt_r[i] <= '0;
    end else begin
      vote_done <= 1'b0;
      if (finish) begin
        state_r     <= CLOSED;
        ndig_r      <= '0;
        bad_r       <= 1'b0;
        tally_valid <= 1'b1;
        tally       <= clear ? '0 : rd_s;
        for (int i = 0; i < NSLOT; i++) begin
          if (clear) cnt_r[i] <= '0;
          else       cnt_r[i] <= cnt_r[i];
        end
      end else begin
        case (state_r)
          CLOSED: begin
            state_r     <= ENTER;
            ndig_r      <= '0;
            bad_r       <= 1'b0;
            tally_valid <= 1'b0;
          end
          ENTER: begin
            if (cancel) begin
              ndig_r <= '0;
              bad_r  <= 1'b0;
            end else if (valid) begin
              code_r <= CODE_W'({code_r, digit});
              ndig_r <= ndig_r + NW'(1);
              bad_r  <= bad_r | (digit > 4'd9);
              if (ndig_r == LAST_DIG) state_r <= WAIT_CONF;
              else                    state_r <= ENTER;
            end else if (cnt_en_s) begin
              vote_done  <= 1'b1;
              votestatus <= 1'b0;
            end else begin
              state_r <= ENTER;
            end
          end
          WAIT_CONF: begin
            if (cancel) begin
              state_r <= ENTER;
              ndig_r  <= '0;
              bad_r   <= 1'b0;
            end else if (confirm) begin
              state_r    <= ENTER;
              ndig_r     <= '0;
              bad_r      <= 1'b0;
              vote_done  <= 1'b1;
              votestatus <= hit_s && !bad_r;
            end else begin
              state_r <= WAIT_CONF;
            end
          end
          default: begin
            state_r <= ENTER;
            ndig_r  <= '0;
            bad_r   <= 1'b0;
          end
        endcase
        for (int i = 0; i < NSLOT; i++) begin
          if (cnt_en_s && cnt_idx_s == 4'(i)) cnt_r[i] <= bump(cnt_r[i]);
          else                                cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_urna_multicandidato.sv
// Directed, table-driven bench for urna_multicandidato with default parameters.
module tb_urna_multicandidato;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       valid = 1'b0;
  logic       confirm = 1'b0;
  logic       cancel = 1'b0;
  logic       finish = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] sel = 4'd0;
  logic [7:0] tally;
  logic       tally_valid;
  logic       vote_done;
  logic       votestatus;

  int total = 0;
  int bad = 0;
  int mc [6];

  typedef struct {
    logic [15:0] code;
    int          nd;
    logic        st;
    int          slot;
  } vec_t;

  vec_t tab [6];

  urna_multicandidato dut (
    .clock(clock), .reset(reset), .digit(digit), .valid(valid),
    .confirm(confirm), .cancel(cancel), .finish(finish), .clear(clear),
    .sel(sel), .tally(tally), .tally_valid(tally_valid),
    .vote_done(vote_done), .votestatus(votestatus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic keys(input logic [15:0] code, input int nd);
    for (int k = 0; k < nd; k++) begin
      valid = 1'b1;
      digit = code[15-4*k -: 4];
      tick();
    end
    valid = 1'b0;
  endtask

  task automatic do_vote(input logic [15:0] code, input int nd, input logic st, input string nm);
    keys(code, nd);
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    chk({nm, "_done"}, vote_done, 1);
    chk({nm, "_status"}, votestatus, st);
    tick();
    chk({nm, "_done_clr"}, vote_done, 0);
  endtask

  task automatic read_all(input string nm);
    finish = 1'b1;
    for (int s = 0; s < 6; s++) begin
      sel = 4'(s);
      tick();
      chk($sformatf("%s_sel%0d", nm, s), tally, mc[s]);
    end
    chk({nm, "_tvalid"}, tally_valid, 1);
  endtask

  initial begin
    tab[0] = '{16'h3474, 4, 1'b1, 0};
    tab[1] = '{16'h3492, 4, 1'b1, 1};
    tab[2] = '{16'h1234, 4, 1'b0, 4};
    tab[3] = '{16'h0000, 0, 1'b0, 5};
    tab[4] = '{16'h3C09, 4, 1'b0, 4};
    tab[5] = '{16'h3509, 4, 1'b1, 3};
    for (int i = 0; i < 6; i++) mc[i] = 0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_tally", tally, 0);
    chk("rst_tvalid", tally_valid, 0);
    chk("rst_done", vote_done, 0);
    chk("rst_status", votestatus, 0);

    for (int i = 0; i < 6; i++) begin
      do_vote(tab[i].code, tab[i].nd, tab[i].st, $sformatf("vec%0d", i));
      mc[tab[i].slot]++;
    end

    // partial code then cancel, followed by a full valid code
    keys(16'h3500, 2);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_no_done", vote_done, 0);
    do_vote(16'h3502, 4, 1'b1, "after_cancel");
    mc[2]++;

    // partial code abandoned by finish: nothing counted
    keys(16'h3500, 3);
    read_all("ro1");
    sel = 4'd7;
    tick();
    chk("ro1_sel7", tally, 0);
    sel = 4'd15;
    tick();
    chk("ro1_sel15", tally, 0);
    sel = 4'd3;
    tick();
    chk("ro1_sel3", tally, 1);
    finish = 1'b0;
    tick();
    chk("unfinish_tvalid", tally_valid, 0);
    chk("unfinish_hold", tally, 1);

    // clear while closed
    finish = 1'b1;
    clear = 1'b1;
    sel = 4'd4;
    tick();
    clear = 1'b0;
    chk("clear_same_edge", tally, 0);
    for (int i = 0; i < 6; i++) mc[i] = 0;
    read_all("ro_clr");
    finish = 1'b0;
    tick();

    // counter boundary: 256 votes for one candidate
    for (int v = 0; v < 256; v++) do_vote(16'h3509, 4, 1'b1, "bulk");
    finish = 1'b1;
    sel = 4'd3;
    tick();
`ifdef URNA_SAT_EN
    chk("bulk_sel3", tally, 255);
`else
    chk("bulk_sel3", tally, 0);
`endif
    finish = 1'b0;
    tick();

    // asynchronous reset in the middle of a code
    do_vote(16'h3474, 4, 1'b1, "pre_rst");
    keys(16'h3400, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_tally", tally, 0);
    chk("async_tvalid", tally_valid, 0);
    chk("async_done", vote_done, 0);
    chk("async_status", votestatus, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) mc[i] = 0;
    do_vote(16'h3474, 4, 1'b1, "post_rst");
    mc[0] = 1;
    read_all("ro_final");
    finish = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/urna_multicandidato.md
# urna_multicandidato

Parametrised ballot-box controller for the voting-machine datapath. It collects decimal key digits into a fixed-length candidate code, waits for an explicit confirm, and then counts the vote against a configurable candidate table. Votes with no digits count as blank; unmatched codes count as null. When `finish` is high, voting is closed and the registered per-candidate, null and blank totals can be read through a select port.

## Interface
Parameters:
- `NUM_CAND`, 4: number of candidates (1..14).
- `CODE_DIGITS`, 4: digits per candidate code (1..6).
- `CNT_W`, 8: width of each vote counter.
- `CODES`, `{16'h3509,16'h3502,16'h3492,16'h3474}`: packed BCD codes, `NUM_CAND*CODE_DIGITS*4` bits. Candidate i occupies slice i; the most significant digit is entered first.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `digit`, in, 4: BCD key value.
- `valid`, in, 1: `digit` is presented this cycle.
- `confirm`, in, 1: confirm the pending vote.
- `cancel`, in, 1: discard the digits entered so far.
- `finish`, in, 1: level; closes voting and enables readout.
- `clear`, in, 1: zeroes all counters; acted on only when `finish`=1.
- `sel`, in, 4: readout select. 0..`NUM_CAND`-1 = candidates, `NUM_CAND` = null, `NUM_CAND`+1 = blank.
- `tally`, out, `CNT_W`: registered readout value.
- `tally_valid`, out, 1: `tally` holds a readout.
- `vote_done`, out, 1: one-cycle pulse when a vote is counted.
- `votestatus`, out, 1: 1 = last vote matched a candidate; 0 = null or blank.

## Operation
- FSM states are ENTER, WAIT_CONF and CLOSED. Reset enters ENTER.
- A digit counter `ndig` (0..`CODE_DIGITS`) and a flag `bad` are cleared on reset, on `cancel`, after each vote, and on any move into or out of CLOSED.
- ENTER:
  - `valid`=1 shifts `digit` into the code register and increments `ndig`.
  - A digit greater than 9 sets `bad`.
  - When `ndig` reaches `CODE_DIGITS`, the FSM moves to WAIT_CONF.
  - `confirm` with `ndig`=0 and `valid`=0 counts a blank vote.
  - `confirm` with 0<`ndig`<`CODE_DIGITS` is ignored.
  - `valid` and `confirm` in the same cycle: the digit is taken and `confirm` is ignored.
- WAIT_CONF:
  - `valid` is ignored.
  - `confirm` compares the code register with every `CODES` slice.
  - If there is a match and `bad`=0, the matched candidate's counter increments and `votestatus`=1.
  - Otherwise the null counter increments and `votestatus`=0.
  - After the vote the FSM returns to ENTER.
- `cancel` in ENTER or WAIT_CONF returns to ENTER with `ndig`=0 and counts nothing. `cancel` takes priority over `confirm` and `valid` in the same cycle.
- Blank vote: the blank counter increments and `votestatus`=0.
- `vote_done`=1 for exactly the one cycle following each counted vote.
- `finish`=1 in any state moves the FSM to CLOSED. A pending vote is discarded without being counted. `finish` takes priority over `confirm`.
- CLOSED:
  - `valid`, `confirm` and `cancel` are ignored.
  - Each cycle, `tally` is loaded with the counter selected by `sel`, and `tally_valid`=1.
  - `sel` greater than `NUM_CAND`+1 gives `tally`=0.
  - `clear`=1 zeroes all counters. `tally` reads 0 on the same edge.
- `finish` falling returns the FSM to ENTER. Counters are kept and `tally_valid` goes to 0 on the next edge; `tally` holds its last value.
- Counter overflow behaviour is set under Configuration.

## Timing
- Reset values: `tally`=0, `tally_valid`=0, `vote_done`=0, `votestatus`=0. All counters are 0 and the state is ENTER.
- `reset` asserted mid-vote or mid-readout applies these values immediately, independent of `clock`.
- Counting happens on the `confirm` edge N. `vote_done` and `votestatus` are valid after edge N and `vote_done` clears after edge N+1.
- Readout latency is 1 cycle: `sel` sampled at edge N is visible on `tally` after edge N.
- A new digit can be accepted on the cycle immediately after a vote is counted.
- `finish` sampled at edge N gives `tally_valid`=1 after edge N.

## Configuration
- `URNA_SAT_EN` defined: every counter saturates at 2^`CNT_W`-1, and further votes for that counter are dropped. `vote_done` and `votestatus` still pulse for those dropped votes.
- `URNA_SAT_EN` undefined: counters wrap modulo 2^`CNT_W`.

## Test plan
All scenarios use the default parameters.
- Keys 3,4,7,4 then `confirm` → `vote_done` pulses, `votestatus`=1; readout with `sel`=0 gives `tally`=1.
- Keys 3,4,9,2 then `confirm` → `sel`=1 gives 1. Keys 1,2,3,4 then `confirm` → `votestatus`=0 and `sel`=4 (null) gives 1.
- `confirm` with no digits → `sel`=5 (blank) gives 1. Keys 3,5 then `cancel`, then 3,5,0,2 `confirm` → `sel`=2 gives 1 and null is unchanged.
- Key value 12 inside a 4-digit code, then `confirm` → null increments. Keys 3,5,0 followed by `finish` → no counter changes. `clear` with `finish`=1 → all selects read 0.
- 256 votes for code 3509 → `sel`=3 reads 255 with `URNA_SAT_EN` defined, 0 without it.
- `reset` pulsed mid-code (after 3,4) → all outputs are 0 immediately. A following 3,4,7,4 `confirm` counts exactly 1 for candidate 0.
